clk_div_multi: RTL

- Parametrised multi-channel successor to the single-channel pulse divider.
- Each channel produces two outputs from one shared clock:
  - a one-cycle tick every (div+1) cycles;
  - a 50% square wave of period 2*(div+1).
- Divider changes are glitch-free: a new value is double-buffered and takes effect only at the channel's terminal count.
- A global sync input phase-aligns all channels.
- Feeds the seven-segment digit-scan, blink and debounce timing.

---
 rtl/clk_div_multi_pkg.sv | 13 +
 rtl/clk_div_ch.sv | 89 ++++++++
 rtl/clk_div_multi.sv | 38 +++
 3 files changed

// File: rtl/clk_div_multi_pkg.sv
// Shared helpers for the multi-channel clock divider: packed-bus slicing
// and channel-index width.
package clk_div_multi_pkg;

  function automatic int unsigned slice_lo(input int unsigned ch, input int unsigned width);
    return ch * width;
  endfunction

  function automatic int unsigned ch_idx_w(input int unsigned num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: counter, active divider, shadow divider with pending
// flag, and registered tick / square-wave outputs.
module clk_div_ch #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_DIV = '0
) (
  input  logic             clk_in,
  input  logic             RST,
  input  logic             sync,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] div_in,
  output logic             tick,
  output logic             sq,
  output logic             pend
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] act_q, act_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic             pend_q, pend_d;
  logic             tick_q, tick_d;
  logic             sq_q, sq_d;
  logic             terminal;

  // >= rather than == so a counter beyond the divider still terminates.
  assign terminal = (cnt_q >= act_q);

  always_comb begin
    cnt_d  = cnt_q;
    act_d  = act_q;
    sh_d   = sh_q;
    pend_d = pend_q;
    tick_d = 1'b0;
    sq_d   = sq_q;
    if (sync || !en) begin
      cnt_d = '0;
      sq_d  = 1'b0;
      if (load) begin
        act_d  = div_in;
        pend_d = 1'b0;
      end else if (pend_q) begin
        act_d  = sh_q;
        pend_d = 1'b0;
      end
    end else if (terminal) begin
      cnt_d  = '0;
      tick_d = 1'b1;
      sq_d   = ~sq_q;
      if (load) begin
        act_d  = div_in;
        pend_d = 1'b0;
      end else if (pend_q) begin
        act_d  = sh_q;
        pend_d = 1'b0;
      end
    end else begin
      cnt_d = cnt_q + WIDTH'(1);
      // Mid-period loads wait in the shadow so the running period is not cut.
      if (load) begin
        sh_d   = div_in;
        pend_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (RST) begin
      cnt_q  <= '0;
      act_q  <= RESET_DIV;
      sh_q   <= '0;
      pend_q <= 1'b0;
      tick_q <= 1'b0;
      sq_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      act_q  <= act_d;
      sh_q   <= sh_d;
      pend_q <= pend_d;
      tick_q <= tick_d;
      sq_q   <= sq_d;
    end
  end

  assign tick = tick_q;
  assign sq   = sq_q;
  assign pend = pend_q;

endmodule

// File: rtl/clk_div_multi.sv
// NUM_CH independent glitch-free dividers sharing clock, reset and a global
// phase-alignment sync.
module clk_div_multi
  import clk_div_multi_pkg::*;
#(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned RESET_DIV = 0
) (
  input  logic                    clk_in,
  input  logic                    RST,
  input  logic                    sync,
  input  logic [NUM_CH-1:0]       en,
  input  logic [NUM_CH-1:0]       load,
  input  logic [NUM_CH*WIDTH-1:0] div_in,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       sq,
  output logic [NUM_CH-1:0]       pend
);

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    clk_div_ch #(
      .WIDTH     (WIDTH),
      .RESET_DIV (WIDTH'(RESET_DIV))
    ) u_ch (
      .clk_in (clk_in),
      .RST    (RST),
      .sync   (sync),
      .en     (en[k]),
      .load   (load[k]),
      .div_in (div_in[slice_lo(k, WIDTH) +: WIDTH]),
      .tick   (tick[k]),
      .sq     (sq[k]),
      .pend   (pend[k])
    );
  end

endmodule
